// File: rtl/rv_pipe_pkg.sv
// Shared encodings and widths for the RV64 pipeline stages.
// Holds ALUOp encodings, internal ALU control codes, funct codes and the ALU decoder.
package rv_pipe_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned REGW = 5;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_SLT = 4'd8
    } alu_ctrl_e;

    // {instr[30], funct3}
    localparam logic [3:0] FUNCT_ADD = 4'b0000;
    localparam logic [3:0] FUNCT_SUB = 4'b1000;
    localparam logic [3:0] FUNCT_AND = 4'b0111;
    localparam logic [3:0] FUNCT_OR  = 4'b0110;
    localparam logic [3:0] FUNCT_XOR = 4'b0100;
    localparam logic [3:0] FUNCT_SLL = 4'b0001;
    localparam logic [3:0] FUNCT_SRL = 4'b0101;
    localparam logic [3:0] FUNCT_SRA = 4'b1101;
    localparam logic [3:0] FUNCT_SLT = 4'b0010;

    localparam logic [2:0] BR_EQ = 3'b000;
    localparam logic [2:0] BR_NE = 3'b001;
    localparam logic [2:0] BR_LT = 3'b100;
    localparam logic [2:0] BR_GE = 3'b101;

    // I-type reuses the R-type table with instr[30] ignored, except for srai.
    function automatic alu_ctrl_e alu_decode(input logic [1:0] alu_op, input logic [3:0] funct);
        logic [3:0] f;
        alu_ctrl_e  ctrl;
        f    = funct;
        ctrl = ALU_ADD;
        if (alu_op == ALUOP_ITYPE && funct != FUNCT_SRA) begin
            f = {1'b0, funct[2:0]};
        end
        case (alu_op)
            ALUOP_ADD:    ctrl = ALU_ADD;
            ALUOP_BRANCH: ctrl = ALU_SUB;
            default: begin
                case (f)
                    FUNCT_ADD: ctrl = ALU_ADD;
                    FUNCT_SUB: ctrl = ALU_SUB;
                    FUNCT_AND: ctrl = ALU_AND;
                    FUNCT_OR:  ctrl = ALU_OR;
                    FUNCT_XOR: ctrl = ALU_XOR;
                    FUNCT_SLL: ctrl = ALU_SLL;
                    FUNCT_SRL: ctrl = ALU_SRL;
                    FUNCT_SRA: ctrl = ALU_SRA;
                    FUNCT_SLT: ctrl = ALU_SLT;
                    default:   ctrl = ALU_ADD;
                endcase
            end
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/ex_mem_stage_alu64.sv
// Combinational 64-bit ALU for the execute stage.
// Shift amounts use the low log2(XLEN) bits of operand B.
module alu64 #(
    parameter int unsigned XLEN = rv_pipe_pkg::XLEN
) (
    input  logic [XLEN-1:0]         a,
    input  logic [XLEN-1:0]         b,
    input  rv_pipe_pkg::alu_ctrl_e  ctrl,
    output logic [XLEN-1:0]         result
);
    import rv_pipe_pkg::*;

    localparam int unsigned SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    logic           lt_signed;

    assign shamt     = b[SHW-1:0];
    assign lt_signed = $signed(a) < $signed(b);

    always_comb begin
        result = a + b;
        case (ctrl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << shamt;
            ALU_SRL: result = a >> shamt;
            ALU_SRA: result = $unsigned($signed(a) >>> shamt);
            ALU_SLT: result = {{(XLEN-1){1'b0}}, lt_signed};
            default: result = a + b;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage of the RV64 pipeline: operand forwarding, ALU, branch resolution,
// EX/MEM pipeline register, load-use stall and branch flush generation.
module ex_mem_stage #(
    parameter int unsigned XLEN = rv_pipe_pkg::XLEN,
    parameter int unsigned REGW = rv_pipe_pkg::REGW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hold,
    input  logic            ID_EX_RegWrite,
    input  logic            ID_EX_MemRead,
    input  logic            ID_EX_MemToReg,
    input  logic            ID_EX_MemWrite,
    input  logic            ID_EX_Branch,
    input  logic            ID_EX_ALUSrc,
    input  logic [1:0]      ID_EX_ALUOp,
    input  logic [XLEN-1:0] ID_EX_PC_out,
    input  logic [XLEN-1:0] ID_EX_ReadData1,
    input  logic [XLEN-1:0] ID_EX_ReadData2,
    input  logic [XLEN-1:0] ID_EX_ImmData,
    input  logic [REGW-1:0] ID_EX_RS1,
    input  logic [REGW-1:0] ID_EX_RS2,
    input  logic [REGW-1:0] ID_EX_RD,
    input  logic [3:0]      ID_EX_Funct,
    input  logic [REGW-1:0] IF_ID_RS1,
    input  logic [REGW-1:0] IF_ID_RS2,
    input  logic            MEM_WB_RegWrite,
    input  logic [REGW-1:0] MEM_WB_RD,
    input  logic [XLEN-1:0] MEM_WB_WriteData,
    output logic            EX_MEM_RegWrite,
    output logic            EX_MEM_MemRead,
    output logic            EX_MEM_MemToReg,
    output logic            EX_MEM_MemWrite,
    output logic            EX_MEM_BranchTaken,
    output logic [XLEN-1:0] EX_MEM_BranchTarget,
    output logic [XLEN-1:0] EX_MEM_ALUResult,
    output logic [XLEN-1:0] EX_MEM_WriteData,
    output logic [REGW-1:0] EX_MEM_RD,
    output logic            stall,
    output logic            flush
);
    import rv_pipe_pkg::*;

    logic            ex_fwd_ok;
    logic            wb_fwd_ok;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] branch_target;
    logic            branch_cond;
    logic            branch_taken;
    alu_ctrl_e       alu_ctrl;

    // A load in EX/MEM has no data yet, so it is never a forwarding source.
    assign ex_fwd_ok = EX_MEM_RegWrite && !EX_MEM_MemToReg && (EX_MEM_RD != '0);
    assign wb_fwd_ok = MEM_WB_RegWrite && (MEM_WB_RD != '0);

    assign op_a = (ex_fwd_ok && EX_MEM_RD == ID_EX_RS1) ? EX_MEM_ALUResult :
                  (wb_fwd_ok && MEM_WB_RD == ID_EX_RS1) ? MEM_WB_WriteData :
                                                          ID_EX_ReadData1;

    assign rs2_val = (ex_fwd_ok && EX_MEM_RD == ID_EX_RS2) ? EX_MEM_ALUResult :
                     (wb_fwd_ok && MEM_WB_RD == ID_EX_RS2) ? MEM_WB_WriteData :
                                                             ID_EX_ReadData2;

    assign op_b     = ID_EX_ALUSrc ? ID_EX_ImmData : rs2_val;
    assign alu_ctrl = alu_decode(ID_EX_ALUOp, ID_EX_Funct);

    alu64 #(.XLEN(XLEN)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .ctrl   (alu_ctrl),
        .result (alu_result)
    );

    // Branch compare always uses the register operand, never the immediate.
    always_comb begin
        branch_cond = 1'b0;
        case (ID_EX_Funct[2:0])
            BR_EQ:   branch_cond = (op_a == rs2_val);
            BR_NE:   branch_cond = (op_a != rs2_val);
            BR_LT:   branch_cond = ($signed(op_a) <  $signed(rs2_val));
            BR_GE:   branch_cond = ($signed(op_a) >= $signed(rs2_val));
            default: branch_cond = 1'b0;
        endcase
    end

    assign branch_taken  = ID_EX_Branch && branch_cond;
    assign branch_target = ID_EX_PC_out + (ID_EX_ImmData << 1);

    // Controls of the wrong-path instruction behind a taken branch are squashed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            EX_MEM_RegWrite     <= 1'b0;
            EX_MEM_MemRead      <= 1'b0;
            EX_MEM_MemToReg     <= 1'b0;
            EX_MEM_MemWrite     <= 1'b0;
            EX_MEM_BranchTaken  <= 1'b0;
            EX_MEM_BranchTarget <= '0;
            EX_MEM_ALUResult    <= '0;
            EX_MEM_WriteData    <= '0;
            EX_MEM_RD           <= '0;
        end else if (!hold) begin
            EX_MEM_BranchTarget <= branch_target;
            EX_MEM_ALUResult    <= alu_result;
            EX_MEM_WriteData    <= rs2_val;
            EX_MEM_RD           <= ID_EX_RD;
            if (EX_MEM_BranchTaken) begin
                EX_MEM_RegWrite    <= 1'b0;
                EX_MEM_MemRead     <= 1'b0;
                EX_MEM_MemToReg    <= 1'b0;
                EX_MEM_MemWrite    <= 1'b0;
                EX_MEM_BranchTaken <= 1'b0;
            end else begin
                EX_MEM_RegWrite    <= ID_EX_RegWrite;
                EX_MEM_MemRead     <= ID_EX_MemRead;
                EX_MEM_MemToReg    <= ID_EX_MemToReg;
                EX_MEM_MemWrite    <= ID_EX_MemWrite;
                EX_MEM_BranchTaken <= branch_taken;
            end
        end
    end

    assign flush = EX_MEM_BranchTaken;
    assign stall = ID_EX_MemRead && (ID_EX_RD != '0) &&
                   ((ID_EX_RD == IF_ID_RS1) || (ID_EX_RD == IF_ID_RS2));

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage with a behavioural reference model checked every cycle.
`timescale 1ns/1ps
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hold = 1'b0;
    logic        rw = 1'b0, mr = 1'b0, mtr = 1'b0, mw = 1'b0, br = 1'b0, src = 1'b0;
    logic [1:0]  aluop = '0;
    logic [63:0] pc = '0, rd1 = '0, rd2 = '0, imm = '0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic [3:0]  funct = '0;
    logic [4:0]  if_rs1 = '0, if_rs2 = '0;
    logic        wb_rw = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [63:0] wb_data = '0;

    logic        o_rw, o_mr, o_mtr, o_mw, o_taken, o_stall, o_flush;
    logic [63:0] o_target, o_alu, o_wdata;
    logic [4:0]  o_rd;

    int unsigned checks = 0;
    int unsigned failures = 0;
    logic        check_en = 1'b0;

    typedef struct packed {
        logic        regwrite, memread, memtoreg, memwrite, taken;
        logic [63:0] target, alu, wdata;
        logic [4:0]  rd;
    } exmem_t;

    exmem_t m = '0;

    typedef struct packed {
        logic [1:0]  op;
        logic [3:0]  fn;
        logic        src;
        logic [63:0] a, b, exp;
    } alu_vec_t;

    localparam logic [63:0] A = 64'h8000_0000_0000_00F0;
    alu_vec_t vecs [0:17] = '{
        '{2'b10, 4'b0001, 1'b0, A, 64'd4, 64'h0000_0000_0000_0F00},
        '{2'b10, 4'b0101, 1'b0, A, 64'd4, 64'h0800_0000_0000_000F},
        '{2'b10, 4'b1101, 1'b0, A, 64'd4, 64'hF800_0000_0000_000F},
        '{2'b10, 4'b0010, 1'b0, A, 64'd4, 64'd1},
        '{2'b10, 4'b0111, 1'b0, A, 64'd4, 64'd0},
        '{2'b10, 4'b0110, 1'b0, A, 64'd4, 64'h8000_0000_0000_00F4},
        '{2'b10, 4'b0100, 1'b0, A, 64'd4, 64'h8000_0000_0000_00F4},
        '{2'b10, 4'b1000, 1'b0, A, 64'd4, 64'h8000_0000_0000_00EC},
        '{2'b11, 4'b1000, 1'b1, A, 64'd4, 64'h8000_0000_0000_00F4},
        '{2'b11, 4'b1101, 1'b1, A, 64'd4, 64'hF800_0000_0000_000F},
        '{2'b11, 4'b0101, 1'b1, A, 64'h44, 64'h0800_0000_0000_000F},
        '{2'b10, 4'b0011, 1'b0, A, 64'd4, 64'h8000_0000_0000_00F4},
        '{2'b10, 4'b1010, 1'b0, A, 64'd4, 64'h8000_0000_0000_00F4},
        '{2'b11, 4'b1010, 1'b1, A, 64'd4, 64'd1},
        '{2'b00, 4'b0000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1},
        '{2'b01, 4'b0000, 1'b0, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF},
        '{2'b10, 4'b0010, 1'b0, 64'd4, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0},
        '{2'b11, 4'b0001, 1'b1, 64'd1, 64'h3F, 64'h8000_0000_0000_0000}
    };

    ex_mem_stage #(.XLEN(64), .REGW(5)) dut (
        .clk                 (clk),
        .reset               (reset),
        .hold                (hold),
        .ID_EX_RegWrite      (rw),
        .ID_EX_MemRead       (mr),
        .ID_EX_MemToReg      (mtr),
        .ID_EX_MemWrite      (mw),
        .ID_EX_Branch        (br),
        .ID_EX_ALUSrc        (src),
        .ID_EX_ALUOp         (aluop),
        .ID_EX_PC_out        (pc),
        .ID_EX_ReadData1     (rd1),
        .ID_EX_ReadData2     (rd2),
        .ID_EX_ImmData       (imm),
        .ID_EX_RS1           (rs1),
        .ID_EX_RS2           (rs2),
        .ID_EX_RD            (rd),
        .ID_EX_Funct         (funct),
        .IF_ID_RS1           (if_rs1),
        .IF_ID_RS2           (if_rs2),
        .MEM_WB_RegWrite     (wb_rw),
        .MEM_WB_RD           (wb_rd),
        .MEM_WB_WriteData    (wb_data),
        .EX_MEM_RegWrite     (o_rw),
        .EX_MEM_MemRead      (o_mr),
        .EX_MEM_MemToReg     (o_mtr),
        .EX_MEM_MemWrite     (o_mw),
        .EX_MEM_BranchTaken  (o_taken),
        .EX_MEM_BranchTarget (o_target),
        .EX_MEM_ALUResult    (o_alu),
        .EX_MEM_WriteData    (o_wdata),
        .EX_MEM_RD           (o_rd),
        .stall               (o_stall),
        .flush               (o_flush)
    );

    always #10 clk = ~clk;

    // Reference: value of a source register as the instruction in EX should see it.
    function automatic logic [63:0] ref_src(input logic [4:0] r, input logic [63:0] file_val);
        if (r != 0 && m.regwrite && !m.memtoreg && m.rd == r) return m.alu;
        if (r != 0 && wb_rw && wb_rd == r) return wb_data;
        return file_val;
    endfunction

    function automatic logic [63:0] ref_alu(input logic [1:0] op, input logic [3:0] f,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [3:0] code;
        code = f;
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        if (op == 2'b11 && f != 4'b1101) code = {1'b0, f[2:0]};
        case (code)
            4'b1000: return a - b;
            4'b0111: return a & b;
            4'b0110: return a | b;
            4'b0100: return a ^ b;
            4'b0001: return a << b[5:0];
            4'b0101: return a >> b[5:0];
            4'b1101: return $signed(a) >>> b[5:0];
            4'b0010: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            default: return a + b;
        endcase
    endfunction

    function automatic exmem_t model_next();
        exmem_t      n;
        logic [63:0] a, s2;
        logic        cond;
        a  = ref_src(rs1, rd1);
        s2 = ref_src(rs2, rd2);
        case (funct[2:0])
            3'b000:  cond = (a == s2);
            3'b001:  cond = (a != s2);
            3'b100:  cond = $signed(a) < $signed(s2);
            3'b101:  cond = $signed(a) >= $signed(s2);
            default: cond = 1'b0;
        endcase
        n.alu      = ref_alu(aluop, funct, a, src ? imm : s2);
        n.wdata    = s2;
        n.rd       = rd;
        n.target   = pc + imm * 2;
        n.regwrite = rw  && !m.taken;
        n.memread  = mr  && !m.taken;
        n.memtoreg = mtr && !m.taken;
        n.memwrite = mw  && !m.taken;
        n.taken    = br && cond && !m.taken;
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset)      m <= '0;
        else if (!hold) m <= model_next();
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("RegWrite",     64'(o_rw),    64'(m.regwrite));
            check("MemRead",      64'(o_mr),    64'(m.memread));
            check("MemToReg",     64'(o_mtr),   64'(m.memtoreg));
            check("MemWrite",     64'(o_mw),    64'(m.memwrite));
            check("BranchTaken",  64'(o_taken), 64'(m.taken));
            check("flush",        64'(o_flush), 64'(m.taken));
            check("BranchTarget", o_target,     m.target);
            check("ALUResult",    o_alu,        m.alu);
            check("WriteData",    o_wdata,      m.wdata);
            check("RD",           64'(o_rd),    64'(m.rd));
            check("stall",        64'(o_stall),
                  64'(mr && rd != 0 && (rd == if_rs1 || rd == if_rs2)));
        end
    end

    task automatic set_instr(input logic i_rw, i_mr, i_mtr, i_mw, i_br, i_src,
                             input logic [1:0] i_op, input logic [3:0] i_fn,
                             input logic [4:0] i_rs1, i_rs2, i_rd,
                             input logic [63:0] i_v1, i_v2, i_imm, i_pc);
        rw = i_rw; mr = i_mr; mtr = i_mtr; mw = i_mw; br = i_br; src = i_src;
        aluop = i_op; funct = i_fn; rs1 = i_rs1; rs2 = i_rs2; rd = i_rd;
        rd1 = i_v1; rd2 = i_v2; imm = i_imm; pc = i_pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic issue(input logic i_rw, i_mr, i_mtr, i_mw, i_br, i_src,
                         input logic [1:0] i_op, input logic [3:0] i_fn,
                         input logic [4:0] i_rs1, i_rs2, i_rd,
                         input logic [63:0] i_v1, i_v2, i_imm, i_pc);
        set_instr(i_rw, i_mr, i_mtr, i_mw, i_br, i_src, i_op, i_fn,
                  i_rs1, i_rs2, i_rd, i_v1, i_v2, i_imm, i_pc);
        tick();
    endtask

    initial begin
        // Reset with busy inputs: registers must stay clear.
        set_instr(1, 1, 1, 1, 1, 0, 2'b10, 4'b0000, 1, 2, 3, 64'd5, 64'd5, 64'd8, 64'h100);
        #1 reset = 1'b1;
        repeat (2) tick();
        check("reset_alu", o_alu, 64'd0);
        check("reset_rw",  64'(o_rw), 64'd0);
        check("reset_taken", 64'(o_taken), 64'd0);
        reset = 1'b0;
        #1;
        check("release_target", o_target, 64'd0);
        check("release_rd", 64'(o_rd), 64'd0);
        set_instr(0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        check_en = 1'b1;
        tick();

        // add x3,x1,x2 then sub x4,x3,x1 with stale x3
        issue(1, 0, 0, 0, 0, 0, 2'b10, 4'b0000, 1, 2, 3, 64'd5, 64'd7, 0, 0);
        check("add_result", o_alu, 64'd12);
        issue(1, 0, 0, 0, 0, 0, 2'b10, 4'b1000, 3, 1, 4, 64'd0, 64'd5, 0, 0);
        check("sub_fwd_result", o_alu, 64'd7);
        check("sub_wdata", o_wdata, 64'd5);

        // EX/MEM beats MEM/WB
        issue(1, 0, 0, 0, 0, 1, 2'b11, 4'b0000, 0, 0, 5, 64'd20, 64'd0, 64'd0, 0);
        wb_rw = 1'b1; wb_rd = 5'd5; wb_data = 64'd99;
        issue(1, 0, 0, 0, 0, 0, 2'b10, 4'b0000, 5, 0, 6, 64'd1, 64'd0, 0, 0);
        check("fwd_priority", o_alu, 64'd20);
        wb_rd = 5'd7;
        issue(1, 0, 0, 0, 0, 0, 2'b10, 4'b0000, 7, 0, 6, 64'd1, 64'd0, 0, 0);
        check("fwd_memwb", o_alu, 64'd99);
        // x0 is never forwarded
        issue(1, 0, 0, 0, 0, 1, 2'b11, 4'b0000, 0, 0, 0, 64'd20, 64'd0, 64'd0, 0);
        wb_rd = 5'd0;
        issue(1, 0, 0, 0, 0, 0, 2'b10, 4'b0000, 0, 0, 6, 64'd1, 64'd0, 0, 0);
        check("fwd_x0", o_alu, 64'd1);
        wb_rw = 1'b0;

        // load-use stall
        mr = 1'b1; rd = 5'd6; if_rs2 = 5'd6; rw = 1'b1; mtr = 1'b1;
        #1 check("stall_rs2", 64'(o_stall), 64'd1);
        rd = 5'd0;
        #1 check("stall_x0", 64'(o_stall), 64'd0);
        rd = 5'd6; if_rs2 = 5'd0; if_rs1 = 5'd6;
        #1 check("stall_rs1", 64'(o_stall), 64'd1);
        tick();
        if_rs1 = 5'd0;

        // blt taken, then squashed wrong-path instruction
        issue(0, 0, 0, 0, 1, 0, 2'b01, 4'b0100, 8, 9, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd8, 64'h100);
        check("blt_taken", 64'(o_taken), 64'd1);
        check("blt_target", o_target, 64'h110);
        check("blt_flush", 64'(o_flush), 64'd1);
        issue(1, 1, 1, 1, 0, 0, 2'b00, 4'b0000, 0, 0, 14, 64'd3, 64'd4, 0, 0);
        check("squash_rw", 64'(o_rw), 64'd0);
        check("squash_mw", 64'(o_mw), 64'd0);
        check("squash_flush", 64'(o_flush), 64'd0);
        check("squash_data", o_alu, 64'd7);
        issue(0, 0, 0, 0, 1, 0, 2'b01, 4'b0101, 8, 9, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd8, 64'h200);
        check("bge_not_taken", 64'(o_taken), 64'd0);
        check("bge_target", o_target, 64'h210);
        issue(0, 0, 0, 0, 1, 1, 2'b01, 4'b0100, 0, 0, 0, 64'd5, 64'd3, 64'd8, 64'h0);
        check("blt_ignores_imm", 64'(o_taken), 64'd0);
        issue(0, 0, 0, 0, 1, 0, 2'b01, 4'b0001, 0, 0, 0, 64'd5, 64'd5, 64'd2, 64'h0);
        issue(0, 0, 0, 0, 1, 0, 2'b01, 4'b0010, 0, 0, 0, 64'd1, 64'd5, 64'd2, 64'h0);

        // ALU vectors
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].src)
                issue(1, 0, 0, 0, 0, 1, vecs[i].op, vecs[i].fn, 0, 0, 13, vecs[i].a, 64'd9, vecs[i].b, 0);
            else
                issue(1, 0, 0, 0, 0, 0, vecs[i].op, vecs[i].fn, 0, 0, 13, vecs[i].a, vecs[i].b, 64'd9, 0);
            check($sformatf("alu_vec%0d", i), o_alu, vecs[i].exp);
        end

        // hold freezes the register
        issue(1, 0, 0, 0, 0, 0, 2'b10, 4'b0000, 0, 0, 10, 64'd100, 64'd1, 0, 0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(1, 1, 0, 1, 0, 0, 2'b10, 4'b0000, 0, 0, 5'(15 + i), 64'(200 + 7 * i), 64'(i), 0, 0);
            check("hold_alu", o_alu, 64'd101);
            check("hold_rd", 64'(o_rd), 64'd10);
        end
        hold = 1'b0;
        issue(1, 0, 0, 0, 0, 0, 2'b10, 4'b0000, 0, 0, 11, 64'd2, 64'd3, 0, 0);
        check("hold_release_alu", o_alu, 64'd5);
        check("hold_release_rd", 64'(o_rd), 64'd11);

        // hold outranks flush
        issue(0, 0, 0, 0, 1, 0, 2'b01, 4'b0000, 0, 0, 0, 64'd0, 64'd0, 64'd4, 64'h40);
        check("beq_target", o_target, 64'h48);
        hold = 1'b1;
        issue(1, 0, 0, 0, 0, 0, 2'b10, 4'b0000, 0, 0, 12, 64'd1, 64'd1, 0, 0);
        check("hold_keeps_flush", 64'(o_flush), 64'd1);
        hold = 1'b0;
        issue(1, 0, 0, 0, 0, 0, 2'b10, 4'b0000, 0, 0, 12, 64'd1, 64'd1, 0, 0);
        check("post_hold_squash", 64'(o_rw), 64'd0);
        check("post_hold_alu", o_alu, 64'd2);

        // asynchronous reset between edges
        issue(1, 1, 0, 1, 0, 0, 2'b10, 4'b0000, 0, 0, 12, 64'd8, 64'd8, 64'd3, 64'h80);
        check("pre_reset_alu", o_alu, 64'd16);
        #2 reset = 1'b1;
        #1;
        check("async_rst_alu", o_alu, 64'd0);
        check("async_rst_rw", 64'(o_rw), 64'd0);
        check("async_rst_target", o_target, 64'd0);
        check("async_rst_wdata", o_wdata, 64'd0);
        check("async_rst_rd", 64'(o_rd), 64'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        tick();
        check_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
